// File: rtl/jesd_pkg.sv
// jesd_pkg: shared JESD204B lane constants, FSM state encodings and link-mux selects.
package jesd_pkg;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARMED = 4'b0010,
    S_RUN   = 4'b0100,
    S_DONE  = 4'b1000
  } ila_state_e;
  // The link FSM raises the ILA sequencer's start level whenever it selects SEL_ILA.
  typedef enum logic [1:0] {
    SEL_DATA = 2'd0,
    SEL_K    = 2'd1,
    SEL_ILA  = 2'd2
  } lane_sel_e;
  typedef struct packed {
    logic       is_k;
    logic [7:0] octet;
  } lane_oct_t;
  function automatic logic ila_selected(lane_sel_e s);
    return s == SEL_ILA;
  endfunction
endpackage

// File: rtl/ila_seq_ctrl_if.sv
// ila_seq_ctrl_if: link-control side and lane-mux side signals of the ILA sequencer.
interface ila_seq_ctrl_if;
  logic         i_start;
  logic         i_lmfc_clk;
  logic [111:0] i_cfg_data;
  logic [7:0]   o_octet;
  logic         o_is_k;
  logic         o_valid;
  logic         o_done;
  logic         o_align_err;
  modport master (
    output i_start, i_lmfc_clk, i_cfg_data,
    input  o_octet, o_is_k, o_valid, o_done, o_align_err
  );
  modport slave (
    input  i_start, i_lmfc_clk, i_cfg_data,
    output o_octet, o_is_k, o_valid, o_done, o_align_err
  );
endinterface

// File: rtl/ila_pos_cnt.sv
// ila_pos_cnt: octet-in-multiframe / multiframe counter pair; holds the position currently on the output.
module ila_pos_cnt #(
  parameter int FK  = 32,
  parameter int NMF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [9:0] nxt_oc,
  output logic [7:0] nxt_mf,
  output logic       last_oc,
  output logic       last_mf
);
  logic [9:0] oc;
  logic [7:0] mf;
  assign last_oc = oc == 10'(FK - 1);
  assign last_mf = mf == 8'(NMF - 1);
  assign nxt_oc  = last_oc ? 10'd0 : oc + 10'd1;
  assign nxt_mf  = last_oc ? mf + 8'd1 : mf;
  // Anything other than advancing parks the counters at the sequence origin.
  always_ff @(posedge clk) begin
    if (rst || !adv) begin
      oc <= '0;
      mf <= '0;
    end else begin
      oc <= nxt_oc;
      mf <= nxt_mf;
    end
  end
endmodule

// File: rtl/ila_seq_ctrl.sv
// ila_seq_ctrl: emits the JESD204B ILA multiframes for one lane, aligned to the LMFC.
module ila_seq_ctrl
  import jesd_pkg::*;
#(
  parameter int F      = 2,
  parameter int K      = 16,
  parameter int ILA_MF = 4
) (
  input logic           clk,
  input logic           rst,
  ila_seq_ctrl_if.slave bus
);
  localparam int FK = F * K;
  ila_state_e state;
  logic [9:0] nxt_oc, sel_oc;
  logic [7:0] nxt_mf, sel_mf;
  logic       last_oc, last_mf, fin, adv;
  logic [3:0] cfg_idx;
  lane_oct_t  sel;
  assign fin = last_oc && last_mf;
  assign adv = state == S_RUN && bus.i_start && !fin;
  ila_pos_cnt #(.FK(FK), .NMF(ILA_MF)) u_pos (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .nxt_oc  (nxt_oc),
    .nxt_mf  (nxt_mf),
    .last_oc (last_oc),
    .last_mf (last_mf)
  );
  // The octet being registered is the one after the displayed position, or (0,0) on the start edge.
  always_comb begin
    sel_oc  = state == S_RUN ? nxt_oc : 10'd0;
    sel_mf  = state == S_RUN ? nxt_mf : 8'd0;
    cfg_idx = 4'(sel_oc - 10'd2);
    sel = (sel_oc == 10'd0)                 ? {1'b1, K28_0}
        : (sel_oc == 10'(FK - 1))           ? {1'b1, K28_3}
        : (sel_mf == 8'd1 && sel_oc == 10'd1) ? {1'b1, K28_4}
        : (sel_mf == 8'd1 && sel_oc >= 10'd2 && sel_oc <= 10'd15)
                                            ? {1'b0, 8'(bus.i_cfg_data >> {cfg_idx, 3'b000})}
        :                                     {1'b0, sel_oc[7:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      bus.o_octet     <= 8'h00;
      bus.o_is_k      <= 1'b0;
      bus.o_valid     <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_align_err <= 1'b0;
    end else begin
      bus.o_octet <= 8'h00;
      bus.o_is_k  <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_done  <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.i_start) state <= S_ARMED;
        S_ARMED: begin
          if (!bus.i_start) state <= S_IDLE;
          else if (bus.i_lmfc_clk) begin
            state       <= S_RUN;
            bus.o_valid <= 1'b1;
            bus.o_octet <= sel.octet;
            bus.o_is_k  <= sel.is_k;
          end
        end
        S_RUN: begin
          if (bus.i_lmfc_clk && !last_oc) bus.o_align_err <= 1'b1;
          if (!bus.i_start) state <= S_IDLE;
          else if (fin) begin
            state      <= S_DONE;
            bus.o_done <= 1'b1;
          end else begin
            bus.o_valid <= 1'b1;
            bus.o_octet <= sel.octet;
            bus.o_is_k  <= sel.is_k;
          end
        end
        S_DONE: if (!bus.i_start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ila_seq_ctrl.sv
// tb_ila_seq_ctrl: scoreboard bench for the ILA sequencer, nominal and minimum-size lanes.
module tb_ila_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ila_seq_ctrl_if a ();
  ila_seq_ctrl_if b ();
  ila_seq_ctrl #(.F(2), .K(16), .ILA_MF(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  ila_seq_ctrl #(.F(1), .K(17), .ILA_MF(4)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  int nchk = 0, nerr = 0, cyc = 0;
  int npa = 0, npb = 0, runa = 0, runb = 0, lasta = 0, lastb = 0;
  int ndone_a = 0, ndone_b = 0, rise_a = 0;
  int ph = 0, pb = 0, base = 0, st = 0, v0 = 0;
  logic pva = 1'b0, pla = 1'b0, pvb = 1'b0, plb = 1'b0;
  bit mon_en = 1'b0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [111:0] cfg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  // cfg octet n is loaded as 0xA0+n below
  function automatic logic [8:0] exp_oct(input int m, input int o, input int fk);
    if (o == 0) return 9'h11C;
    if (o == fk - 1) return 9'h17C;
    if (m == 1 && o == 1) return 9'h19C;
    if (m == 1 && o >= 2 && o <= 15) return {1'b0, 8'(8'hA0 + o - 2)};
    return {1'b0, 8'(o)};
  endfunction

  task automatic push(input bit to_b, input int fk, input int n);
    for (int i = 0; i < n; i++)
      if (to_b) qb.push_back(exp_oct(i / fk, i % fk, fk));
      else qa.push_back(exp_oct(i / fk, i % fk, fk));
  endtask

  always @(negedge clk) if (mon_en) begin
    if (a.o_valid) begin
      if (qa.size() == 0) chk("a_extra_octet", qa.size(), 1);
      else chk("a_octet", {a.o_is_k, a.o_octet}, qa.pop_front());
      if (!pva) begin
        chk("a_start_latency", pla, 1);
        rise_a = cyc;
      end
      runa++;
      npa++;
    end else begin
      chk("a_idle_zero", {a.o_is_k, a.o_octet}, 0);
      if (pva) lasta = runa;
      runa = 0;
    end
    if (a.o_done) begin
      ndone_a++;
      chk("a_done_after_last", {pva, qa.size() == 0, a.o_valid}, 3'b110);
    end
    pva = a.o_valid;
    pla = a.i_lmfc_clk;
  end

  always @(negedge clk) if (mon_en) begin
    if (b.o_valid) begin
      if (qb.size() == 0) chk("b_extra_octet", qb.size(), 1);
      else chk("b_octet", {b.o_is_k, b.o_octet}, qb.pop_front());
      if (!pvb) chk("b_start_latency", plb, 1);
      runb++;
      npb++;
    end else begin
      chk("b_idle_zero", {b.o_is_k, b.o_octet}, 0);
      if (pvb) lastb = runb;
      runb = 0;
    end
    if (b.o_done) begin
      ndone_b++;
      chk("b_done_after_last", {pvb, qb.size() == 0, b.o_valid}, 3'b110);
    end
    pvb = b.o_valid;
    plb = b.i_lmfc_clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 32;
    pb = (pb + 1) % 17;
    a.i_lmfc_clk = (ph == 31);
    b.i_lmfc_clk = (pb == 16);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pop_a(input int n, input int budget);
    for (int i = 0; i < budget && npa < n; i++) begin
      step();
      settle();
    end
    chk("a_reach_octet", npa, n);
  endtask

  task automatic wait_done(input bit on_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      settle();
      seen = on_b ? b.o_done : a.o_done;
    end
    chk(on_b ? "b_done_timeout" : "a_done_timeout", seen, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_octet"}, a.o_octet, 0);
    chk({nm, "_is_k"}, a.o_is_k, 0);
    chk({nm, "_valid"}, a.o_valid, 0);
    chk({nm, "_done"}, a.o_done, 0);
    chk({nm, "_align_err"}, a.o_align_err, 0);
  endtask

  initial begin
    for (int n = 0; n < 14; n++) cfg[8*n +: 8] = 8'(8'hA0 + n);
    a.i_start = 1'b0; a.i_lmfc_clk = 1'b0; a.i_cfg_data = cfg;
    b.i_start = 1'b0; b.i_lmfc_clk = 1'b0; b.i_cfg_data = cfg;
    repeat (3) @(posedge clk);
    settle();
    chk_zero("reset");
    mon_en = 1'b1;
    rst = 1'b0;

    // nominal 4x32 sequence
    a.i_start = 1'b1;
    push(1'b0, 32, 128);
    wait_done(1'b0, 400);
    chk("nom_queue_left", qa.size(), 0);
    chk("nom_valid_run", lasta, 128);
    chk("nom_done_count", ndone_a, 1);
    chk("nom_align_err", a.o_align_err, 0);

    // DONE holds with start still high
    v0 = npa;
    repeat (100) begin step(); settle(); end
    chk("hold_no_octets", npa, v0);
    chk("hold_done_count", ndone_a, 1);
    chk("hold_valid", a.o_valid, 0);
    a.i_start = 1'b0;
    step(); settle();

    // abort at mf2 oc5
    a.i_start = 1'b1;
    base = npa;
    push(1'b0, 32, 70);
    wait_pop_a(base + 70, 200);
    a.i_start = 1'b0;
    step(); settle();
    chk("abort_valid", a.o_valid, 0);
    chk("abort_octet", a.o_octet, 0);
    chk("abort_no_done", ndone_a, 1);
    chk("abort_queue_left", qa.size(), 0);
    chk("abort_valid_run", lasta, 70);

    // restart with start raised in an LMFC cycle: that pulse is missed
    while (ph != 30) step();
    step();
    a.i_start = 1'b1;
    st = cyc;
    push(1'b0, 32, 128);
    wait_done(1'b0, 400);
    chk("restart_latency", rise_a - st, 33);
    chk("restart_valid_run", lasta, 128);
    chk("restart_done_count", ndone_a, 2);
    chk("restart_queue_left", qa.size(), 0);

    // extra LMFC at mf1 oc10
    a.i_start = 1'b0;
    step(); settle();
    chk("mis_err_before", a.o_align_err, 0);
    a.i_start = 1'b1;
    base = npa;
    push(1'b0, 32, 128);
    wait_pop_a(base + 43, 200);
    a.i_lmfc_clk = 1'b1;
    step(); settle();
    chk("mis_err_set", a.o_align_err, 1);
    wait_done(1'b0, 400);
    chk("mis_err_sticky", a.o_align_err, 1);
    chk("mis_valid_run", lasta, 128);
    chk("mis_done_count", ndone_a, 3);
    chk("mis_queue_left", qa.size(), 0);

    // reset at mf3 oc20
    a.i_start = 1'b0;
    step(); settle();
    a.i_start = 1'b1;
    base = npa;
    push(1'b0, 32, 117);
    wait_pop_a(base + 117, 200);
    rst = 1'b1;
    a.i_start = 1'b0;
    step(); settle();
    chk_zero("rst_mid");
    chk("rst_queue_left", qa.size(), 0);
    chk("rst_no_done", ndone_a, 3);
    rst = 1'b0;
    step(); settle();

    // minimum-size lane F=1 K=17
    b.i_start = 1'b1;
    push(1'b1, 17, 68);
    wait_done(1'b1, 300);
    chk("min_queue_left", qb.size(), 0);
    chk("min_valid_run", lastb, 68);
    chk("min_done_count", ndone_b, 1);
    chk("min_align_err", b.o_align_err, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
